// File: rtl/data_mover_bram_pkg.sv
// Shared widths, state encoding and lane helper
// for the BRAM-fed four-lane dot-product mover.
package data_mover_bram_pkg;

  localparam int CNT_BIT_D       = 31;
  localparam int DWIDTH_D        = 32;
  localparam int AWIDTH_D        = 12;
  localparam int MEM_SIZE_D      = 4096;
  localparam int IN_DATA_WITDH_D = 8;
  localparam int NUM_CORE        = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Lane j takes the j-th byte counted from the MSB end.
  function automatic logic [IN_DATA_WITDH_D-1:0] lane_byte(
    input logic [DWIDTH_D-1:0] w,
    input int                  j
  );
    return w[DWIDTH_D-1-IN_DATA_WITDH_D*j -: IN_DATA_WITDH_D];
  endfunction

endpackage

// File: rtl/data_mover_bram_mac_lane.sv
// One 8x8 unsigned multiply register feeding
// a wrapping accumulator.
module data_mover_mac_lane #(
  parameter int IW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          mul_en,
  input  logic          acc_en,
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [2*IW-1:0] prod;

  // Product stage then accumulate; clr wipes both.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en)
        prod <= {{IW{1'b0}}, a} * {{IW{1'b0}}, b};
      if (acc_en)
        acc <= acc + DW'(prod);
    end
  end

endmodule

// File: rtl/true_dpbram.sv
// True dual-port block RAM with registered reads.
// Port 0 takes priority on same-address writes.
module true_dpbram #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 4096
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] addr0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DWIDTH-1:0] d0,
  output logic [DWIDTH-1:0] q0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic              ce1,
  input  logic              we1,
  input  logic [DWIDTH-1:0] d1,
  output logic [DWIDTH-1:0] q1
);

  logic [DWIDTH-1:0] ram [MEM_SIZE];

  // Writes; port 0 is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (ce1 && we1) ram[addr1] <= d1;
    if (ce0 && we0) ram[addr0] <= d0;
  end

  // Port 0 read; q holds when not reading.
  always_ff @(posedge clk) begin
    if (ce0 && !we0) q0 <= ram[addr0];
  end

  // Port 1 read; q holds when not reading.
  always_ff @(posedge clk) begin
    if (ce1 && !we1) q1 <= ram[addr1];
  end

endmodule

// File: rtl/data_mover_bram.sv
// Reads N word pairs from two BRAMs and forms
// four byte-lane unsigned dot products.
import data_mover_bram_pkg::*;

module data_mover_bram #(
  parameter int CNT_BIT       = CNT_BIT_D,
  parameter int DWIDTH        = DWIDTH_D,
  parameter int AWIDTH        = AWIDTH_D,
  parameter int MEM_SIZE      = MEM_SIZE_D,
  parameter int IN_DATA_WITDH = IN_DATA_WITDH_D
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_write,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr_b0,
  output logic               ce_b0,
  output logic               we_b0,
  output logic [DWIDTH-1:0]  d_b0,
  input  logic [DWIDTH-1:0]  q_b0,
  output logic [AWIDTH-1:0]  addr_b1,
  output logic               ce_b1,
  output logic               we_b1,
  output logic [DWIDTH-1:0]  d_b1,
  input  logic [DWIDTH-1:0]  q_b1,
  output logic [DWIDTH-1:0]  result_0,
  output logic [DWIDTH-1:0]  result_1,
  output logic [DWIDTH-1:0]  result_2,
  output logic [DWIDTH-1:0]  result_3
);

  state_t             state;
  logic [CNT_BIT-1:0] n_reg;
  logic [CNT_BIT-1:0] cnt;
  logic               drain;
  logic               rd_v;
  logic               mul_v;
  logic               run_acc;
  logic [DWIDTH-1:0]  res [NUM_CORE];

  assign run_acc = (state == S_IDLE) && i_run;

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state  <= S_IDLE;
      n_reg  <= '0;
      cnt    <= '0;
      drain  <= 1'b0;
      o_idle <= 1'b1;
      o_read <= 1'b0;
      o_done <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_run) begin
            n_reg  <= i_num_cnt;
            cnt    <= '0;
            o_idle <= 1'b0;
            if (i_num_cnt == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= S_RUN;
              o_read <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt == n_reg - CNT_BIT'(1)) begin
            state  <= S_DRAIN;
            o_read <= 1'b0;
            drain  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_BIT'(1);
          end
        end
        S_DRAIN: begin
          if (drain) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            drain <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_idle <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid pipe: BRAM data, then product register.
  always_ff @(posedge clk) begin
    if (reset_n || run_acc) begin
      rd_v  <= 1'b0;
      mul_v <= 1'b0;
    end else begin
      rd_v  <= o_read;
      mul_v <= rd_v;
    end
  end

  assign o_write = mul_v;

  assign addr_b0 = cnt[AWIDTH-1:0];
  assign addr_b1 = cnt[AWIDTH-1:0];
  assign ce_b0   = o_read;
  assign ce_b1   = o_read;
  assign we_b0   = 1'b0;
  assign we_b1   = 1'b0;
  assign d_b0    = '0;
  assign d_b1    = '0;

  for (genvar j = 0; j < NUM_CORE; j++) begin : g_lane
    data_mover_mac_lane #(
      .IW (IN_DATA_WITDH),
      .DW (DWIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (reset_n),
      .clr    (run_acc),
      .mul_en (rd_v),
      .acc_en (mul_v),
      .a      (lane_byte(q_b0, j)),
      .b      (lane_byte(q_b1, j)),
      .acc    (res[j])
    );
  end

  assign result_0 = res[0];
  assign result_1 = res[1];
  assign result_2 = res[2];
  assign result_3 = res[3];

endmodule

// File: tb/tb_data_mover_bram.sv
// Directed vector bench for data_mover_bram
// with two preloaded true_dpbram banks.
module tb_data_mover_bram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_run = 1'b0;
  logic [30:0] i_num_cnt = '0;
  logic        o_idle, o_read, o_write, o_done;
  logic [11:0] addr_b0, addr_b1;
  logic        ce_b0, ce_b1, we_b0, we_b1;
  logic [31:0] d_b0, d_b1, q_b0, q_b1;
  logic [31:0] q1_b0, q1_b1;
  logic [31:0] result_0, result_1, result_2, result_3;

  always #5 clk = ~clk;

  data_mover_bram dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_read    (o_read),
    .o_write   (o_write),
    .o_done    (o_done),
    .addr_b0   (addr_b0),
    .ce_b0     (ce_b0),
    .we_b0     (we_b0),
    .d_b0      (d_b0),
    .q_b0      (q_b0),
    .addr_b1   (addr_b1),
    .ce_b1     (ce_b1),
    .we_b1     (we_b1),
    .d_b1      (d_b1),
    .q_b1      (q_b1),
    .result_0  (result_0),
    .result_1  (result_1),
    .result_2  (result_2),
    .result_3  (result_3)
  );

  true_dpbram u_b0 (
    .clk (clk),
    .addr0 (addr_b0), .ce0 (ce_b0), .we0 (we_b0),
    .d0 (d_b0), .q0 (q_b0),
    .addr1 (12'd0), .ce1 (1'b0), .we1 (1'b0),
    .d1 (32'd0), .q1 (q1_b0)
  );

  true_dpbram u_b1 (
    .clk (clk),
    .addr0 (addr_b1), .ce0 (ce_b1), .we0 (we_b1),
    .d0 (d_b1), .q0 (q_b1),
    .addr1 (12'd0), .ce1 (1'b0), .we1 (1'b0),
    .d1 (32'd0), .q1 (q1_b1)
  );

  typedef struct packed {
    logic [30:0]      n;
    logic [3:0][31:0] w0;
    logic [3:0][31:0] w1;
    logic [31:0]      f0;
    logic [31:0]      f1;
    logic [3:0][31:0] r;
    logic [31:0]      dcyc;
    logic             pulse;
  } vec_t;

  vec_t vt [6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " idle"}, 32'(o_idle), 32'd1);
    chk({tag, " read"}, 32'(o_read), 32'd0);
    chk({tag, " write"}, 32'(o_write), 32'd0);
    chk({tag, " done"}, 32'(o_done), 32'd0);
    chk({tag, " ce_we"}, {28'd0, ce_b0, ce_b1, we_b0, we_b1}, 32'd0);
    chk({tag, " addr"}, {8'd0, addr_b0, addr_b1}, 32'd0);
    chk({tag, " r0"}, result_0, 32'd0);
    chk({tag, " r1"}, result_1, 32'd0);
    chk({tag, " r2"}, result_2, 32'd0);
    chk({tag, " r3"}, result_3, 32'd0);
  endtask

  function automatic vec_t mk(
    input logic [30:0] n,
    input logic [127:0] w0, input logic [127:0] w1,
    input logic [31:0] f0, input logic [31:0] f1,
    input logic [127:0] r, input int d, input logic p);
    vec_t v;
    v.n = n; v.w0 = w0; v.w1 = w1;
    v.f0 = f0; v.f1 = f1; v.r = r;
    v.dcyc = d; v.pulse = p;
    return v;
  endfunction

  task automatic preload(input vec_t v);
    for (int i = 0; i < 4096; i++) begin
      u_b0.ram[i] = (i < 4) ? v.w0[i] : v.f0;
      u_b1.ram[i] = (i < 4) ? v.w1[i] : v.f1;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the
  // negedge of cycle N+4 so the next run can start there.
  task automatic run_vec(input int idx);
    vec_t v;
    int cyc, rd, ce, wr, il, dc;
    bit seen;
    logic [31:0] r [4];
    string tag;
    v = vt[idx];
    tag = $sformatf("v%0d", idx);
    preload(v);
    i_num_cnt = v.n;
    i_run = 1'b1;
    @(posedge clk); #1 i_run = 1'b0;
    cyc = 1; rd = 0; ce = 0; wr = 0; il = 0; dc = 0;
    seen = 1'b0;
    r = '{default: '0};
    while (!seen && cyc < 5000) begin
      @(negedge clk);
      if (o_read) rd++;
      if (ce_b0 || ce_b1) ce++;
      if (o_write) wr++;
      if (!o_idle) il++;
      if (o_done) begin
        seen = 1'b1;
        dc = cyc;
        r[0] = result_0; r[1] = result_1;
        r[2] = result_2; r[3] = result_3;
      end else begin
        if (v.pulse && cyc == 2) i_run = 1'b1;
        @(posedge clk); #1 i_run = 1'b0;
        cyc++;
      end
    end
    chk({tag, " done_cycle"}, dc, v.dcyc);
    chk({tag, " read_cycles"}, rd, 32'(v.n));
    chk({tag, " ce_cycles"}, ce, 32'(v.n));
    chk({tag, " write_cycles"}, wr, 32'(v.n));
    chk({tag, " idle_low"}, il, v.dcyc);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s result_%0d", tag, j), r[j], v.r[j]);
    @(negedge clk);
    chk({tag, " done_width"}, 32'(o_done), 32'd0);
    chk({tag, " idle_after"}, 32'(o_idle), 32'd1);
    chk({tag, " hold_r0"}, result_0, v.r[0]);
    chk({tag, " hold_r3"}, result_3, v.r[3]);
  endtask

  initial begin
    vt[0] = mk(31'd1,
      {32'h0, 32'h0, 32'h0, 32'h01020304},
      {32'h0, 32'h0, 32'h0, 32'h05060708},
      32'h0, 32'h0,
      {32'd32, 32'd21, 32'd12, 32'd5}, 4, 1'b0);
    vt[1] = mk(31'd4096,
      {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}},
      32'hFFFFFFFF, 32'hFFFFFFFF,
      {4{32'd266342400}}, 4099, 1'b0);
    vt[2] = mk(31'd0,
      {4{32'h11111111}}, {4{32'h22222222}},
      32'h11111111, 32'h22222222,
      {4{32'd0}}, 1, 1'b0);
    vt[3] = mk(31'd3,
      {32'h0, 32'h03030303, 32'h02020202, 32'h01010101},
      {4{32'h01020304}},
      32'h0, 32'h01020304,
      {32'd24, 32'd18, 32'd12, 32'd6}, 6, 1'b0);
    vt[4] = mk(31'd2,
      {32'h0, 32'h0, 32'h01000000, 32'h10203040},
      {32'h0, 32'h0, 32'hFF000000, 32'h02030405},
      32'h0, 32'h0,
      {32'd320, 32'd192, 32'd96, 32'd287}, 5, 1'b1);
    vt[5] = mk(31'd4097,
      {32'h0, 32'h0, 32'h0, 32'h01010101},
      {32'h0, 32'h0, 32'h0, 32'h01010101},
      32'h0, 32'h0,
      {4{32'd2}}, 4100, 1'b0);

    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of a long run.
    preload(vt[1]);
    i_num_cnt = 31'd4096;
    i_run = 1'b1;
    @(posedge clk); #1 i_run = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrun busy", {30'd0, o_read, o_write}, 32'd3);
    chk("midrun r0 nonzero", 32'(result_0 != 0), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk_reset("midrun_rst");
    run_vec(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
